// File: rtl/slice_ctrl_pkg.sv
// Shared constants and FSM encoding for the subtract-slice sequencer.
package slice_ctrl_pkg;
  localparam int SLICE_W = 4;
  localparam int MODE_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/slice_seq_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: grant is combinational, pointer moves on advance.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic ptr_q;

  // Contention goes to the pointer side; a lone requester always wins.
  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
  end

  // Pointer lands one past the granted requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr_q <= 1'b0;
    else if (advance) ptr_q <= ~gnt[1];
  end
endmodule

// File: rtl/slice_seq_ctrl.sv
// Sequences wide subtracts through a shared 4-bit slice, one nibble per cycle.
module slice_seq_ctrl
  import slice_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int NREQ    = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*SLICE_W*NIBBLES-1:0] req_v,
  input  logic [NREQ*MODE_W-1:0]       req_p,
  input  logic [NREQ-1:0]              req_bin,
  output logic [SLICE_W-1:0]           slice_v,
  output logic [MODE_W-1:0]            slice_p,
  output logic                         slice_bin,
  input  logic [SLICE_W-1:0]           slice_diff,
  input  logic                         slice_bout,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic                         rsp_id,
  output logic [SLICE_W*NIBBLES-1:0]   rsp_diff,
  output logic                         rsp_bout,
  output logic                         busy
);
  localparam int W     = SLICE_W * NIBBLES;
  localparam int NIB_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e            state_q, state_d;
  logic [NIB_W-1:0]  nib_q;
  logic [W-1:0]      op_q, res_q;
  logic [MODE_W-1:0] p_q;
  logic              bin_q, borrow_q, id_q;
  logic [NREQ-1:0]   gnt;
  logic              accept, gid, last_nib;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt)
  );

  // Grants are only visible in IDLE and are forced low while reset is held.
  assign req_ready = (state_q == IDLE && rst_n) ? gnt : '0;
  assign accept    = (state_q == IDLE) && (|gnt);
  assign gid       = gnt[1];
  assign last_nib  = (nib_q == NIB_W'(NIBBLES - 1));

  assign rsp_valid = (state_q == DONE);
  assign rsp_id    = id_q;
  assign rsp_diff  = res_q;
  assign rsp_bout  = borrow_q;
  assign busy      = (state_q != IDLE);

  // Slice is driven only in RUN; first nibble uses the requester's borrow-in.
  always_comb begin
    slice_v   = '0;
    slice_p   = '0;
    slice_bin = 1'b0;
    if (state_q == RUN) begin
      slice_v   = op_q[int'(nib_q)*SLICE_W +: SLICE_W];
      slice_p   = p_q;
      slice_bin = (nib_q == '0) ? bin_q : borrow_q;
    end
  end

  // Next-state: accept -> RUN for NIBBLES cycles -> DONE until consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_nib) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operation registers: latch request on accept, collect nibbles in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      nib_q    <= '0;
      op_q     <= '0;
      res_q    <= '0;
      p_q      <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      id_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= req_v[int'(gid)*W +: W];
        p_q   <= req_p[int'(gid)*MODE_W +: MODE_W];
        bin_q <= req_bin[gid];
        id_q  <= gid;
        nib_q <= '0;
      end else if (state_q == RUN) begin
        res_q[int'(nib_q)*SLICE_W +: SLICE_W] <= slice_diff;
        borrow_q <= slice_bout;
        nib_q    <= nib_q + NIB_W'(1);
      end
    end
  end
endmodule
